sram_mem_ctrl: RTL and testbench

Multi-cycle memory-stage controller between the EXE/MEM pipeline register and an external 16-bit asynchronous SRAM; it replaces the single-cycle data memory path. It converts one 32-bit load/store request into two 16-bit SRAM accesses with programmable wait states. It deasserts `ready` so the hazard/freeze logic stalls every pipeline register until the access completes.

---
 rtl/sram_ctrl_pkg.sv | 17 +
 rtl/sram_addr_map.sv | 19 +
 rtl/sram_mem_ctrl.sv | 121 ++++++++++++
 tb/tb_sram_mem_ctrl.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_ctrl_pkg.sv
// Shared types and defaults for the two-phase 16-bit SRAM memory-stage controller.
package sram_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LO,
        HI,
        DONE
    } state_t;

    localparam logic HALF_LO = 1'b0;
    localparam logic HALF_HI = 1'b1;

    localparam int          DEF_ACCESS_CYCLES = 5;
    localparam logic [31:0] DEF_BASE_ADDR     = 32'd1024;

endpackage

// File: rtl/sram_addr_map.sv
// CPU byte address to SRAM half-word address: base removal, word index, half select.
module sram_addr_map #(
    parameter int          SRAM_AW   = 18,
    parameter logic [31:0] BASE_ADDR = 32'd1024
) (
    input  logic [31:0]        addr,
    input  logic               half,
    output logic [SRAM_AW-1:0] sram_addr
);

    logic [31:0] offset;
    logic        unused_bits;

    // Wraps modulo 2^32 so addresses below the base alias to the top of the SRAM.
    assign offset      = addr - BASE_ADDR;
    assign sram_addr   = {offset[SRAM_AW:2], half};
    assign unused_bits = ^{offset[31:SRAM_AW+1], offset[1:0]};

endmodule

// File: rtl/sram_mem_ctrl.sv
// Memory-stage controller: one 32-bit load/store becomes two 16-bit SRAM accesses
// of ACCESS_CYCLES cycles each; ready stays low to freeze the pipeline meanwhile.
module sram_mem_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter int          ACCESS_CYCLES = DEF_ACCESS_CYCLES,
    parameter int          SRAM_AW       = 18,
    parameter logic [31:0] BASE_ADDR     = DEF_BASE_ADDR
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rd_en,
    input  logic               wr_en,
    input  logic [31:0]        addr,
    input  logic [31:0]        wdata,
    output logic [31:0]        rdata,
    output logic               ready,
    output logic [SRAM_AW-1:0] sram_addr,
    output logic [15:0]        sram_dq_o,
    input  logic [15:0]        sram_dq_i,
    output logic               sram_dq_oe,
    output logic               sram_we_n
);

    localparam int               CNT_W  = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;
    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(ACCESS_CYCLES - 1);

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic               op_wr;
    logic [31:0]        addr_q;
    logic [15:0]        wdata_hi_q;
    logic               req;
    logic               last;
    logic [31:0]        map_addr;
    logic               map_half;
    logic [SRAM_AW-1:0] map_out;

    assign req  = rd_en | wr_en;
    assign last = (cnt == '0);

    // The mapper serves the LO address on request capture and the HI address at the LO->HI turn.
    assign map_addr = (state == IDLE) ? addr : addr_q;
    assign map_half = (state == IDLE) ? HALF_LO : HALF_HI;

    sram_addr_map #(
        .SRAM_AW   (SRAM_AW),
        .BASE_ADDR (BASE_ADDR)
    ) u_addr_map (
        .addr      (map_addr),
        .half      (map_half),
        .sram_addr (map_out)
    );

    always_comb begin
        state_nxt  = state;
        ready      = 1'b0;
        sram_we_n  = 1'b1;
        sram_dq_oe = 1'b0;
        case (state)
            IDLE: begin
                ready = !req;
                if (req) state_nxt = LO;
            end
            LO, HI: begin
                sram_dq_oe = op_wr;
                // The final cycle of each phase releases we_n while data is still driven.
                sram_we_n  = !(op_wr && !last);
                if (last) state_nxt = (state == LO) ? HI : DONE;
            end
            DONE: begin
                ready     = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            op_wr     <= 1'b0;
            rdata     <= '0;
            sram_addr <= '0;
            sram_dq_o <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: if (req) begin
                    cnt       <= RELOAD;
                    op_wr     <= wr_en;
                    sram_addr <= map_out;
                    if (wr_en) sram_dq_o <= wdata[15:0];
                end
                LO: if (last) begin
                    cnt       <= RELOAD;
                    sram_addr <= map_out;
                    if (op_wr) sram_dq_o <= wdata_hi_q;
                    else       rdata[15:0] <= sram_dq_i;
                end else begin
                    cnt <= cnt - CNT_W'(1);
                end
                HI: if (last) begin
                    if (!op_wr) rdata[31:16] <= sram_dq_i;
                end else begin
                    cnt <= cnt - CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (state == IDLE && req) begin
            addr_q     <= addr;
            wdata_hi_q <= wdata[31:16];
        end
    end

endmodule

// File: tb/tb_sram_mem_ctrl.sv
// Scoreboarded bench: an N=5 controller on a write-on-we_n-release SRAM model and an
// N=1 controller on a read-only address-pattern SRAM.
module tb_sram_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sel = 1'b0;
    logic        req_rd = 1'b0, req_wr = 1'b0;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic        nxt_rd = 1'b0, nxt_wr = 1'b0;
    logic [31:0] nxt_addr = '0, nxt_wdata = '0;

    logic [31:0] rdata0, rdata1;
    logic        ready0, ready1, oe0, oe1, we0, we1;
    logic [17:0] sa0, sa1;
    logic [15:0] dqo0, dqo1, dqi0, dqi1;

    logic [15:0] mem0 [0:262143];
    logic        pend0 = 1'b0;
    logic [17:0] pa0;
    logic [15:0] pd0;
    logic [15:0] model0 [int];
    logic [31:0] exp_q [$];
    int          we_low_cnt = 0;
    int          n_cmp = 0, n_bad = 0;

    always #5 clk = ~clk;

    sram_mem_ctrl #(.ACCESS_CYCLES(5), .SRAM_AW(18), .BASE_ADDR(32'd1024)) dut0 (
        .clk(clk), .rst(rst), .rd_en(req_rd & !sel), .wr_en(req_wr & !sel),
        .addr(req_addr), .wdata(req_wdata), .rdata(rdata0), .ready(ready0),
        .sram_addr(sa0), .sram_dq_o(dqo0), .sram_dq_i(dqi0), .sram_dq_oe(oe0), .sram_we_n(we0));

    sram_mem_ctrl #(.ACCESS_CYCLES(1), .SRAM_AW(18), .BASE_ADDR(32'd1024)) dut1 (
        .clk(clk), .rst(rst), .rd_en(req_rd & sel), .wr_en(req_wr & sel),
        .addr(req_addr), .wdata(req_wdata), .rdata(rdata1), .ready(ready1),
        .sram_addr(sa1), .sram_dq_o(dqo1), .sram_dq_i(dqi1), .sram_dq_oe(oe1), .sram_we_n(we1));

    function automatic logic [15:0] pat(input int unsigned a);
        return 16'(a) ^ 16'h5A3C;
    endfunction

    // Asynchronous SRAM: data is latched while we_n is low and committed on its release.
    always @(posedge clk) begin
        if (!we0) begin
            pend0 <= 1'b1; pa0 <= sa0; pd0 <= dqo0;
        end else begin
            if (pend0 && oe0) mem0[pa0] <= pd0;
            pend0 <= 1'b0;
        end
    end
    assign dqi0 = oe0 ? 16'h0 : mem0[sa0];
    assign dqi1 = oe1 ? 16'h0 : pat(int'(sa1));

    wire        ready_s = sel ? ready1 : ready0;
    wire [31:0] rdata_s = sel ? rdata1 : rdata0;
    wire [17:0] sa_s    = sel ? sa1 : sa0;
    wire [15:0] dqo_s   = sel ? dqo1 : dqo0;
    wire        oe_s    = sel ? oe1 : oe0;
    wire        we_s    = sel ? we1 : we0;

    always @(posedge clk) if (!we_s) we_low_cnt <= we_low_cnt + 1;

    function automatic int unsigned exp_sa(input logic [31:0] a, input bit hi);
        int unsigned w;
        w = ((a - 32'd1024) >> 2) % 131072;
        return w * 2 + (hi ? 1 : 0);
    endfunction

    function automatic logic [15:0] mrd(input int unsigned i);
        return model0.exists(i) ? model0[i] : 16'h0;
    endfunction

    task automatic issue(input bit wr, input bit rd, input logic [31:0] a, input logic [31:0] d);
        int unsigned lo, hi;
        req_wr = wr; req_rd = rd; req_addr = a; req_wdata = d;
        lo = exp_sa(a, 0); hi = exp_sa(a, 1);
        if (wr && !sel) begin
            model0[lo] = d[15:0]; model0[hi] = d[31:16];
        end else if (rd && !wr) begin
            exp_q.push_back(sel ? {pat(hi), pat(lo)} : {mrd(hi), mrd(lo)});
        end
    endtask

    // Called in the request cycle; returns at the negedge after DONE with nxt_* applied.
    task automatic xfer(input bit wr, input logic [31:0] a, input logic [31:0] d);
        int n, low, we_start;
        logic [31:0] want;
        n = sel ? 1 : 5;
        low = 0;
        #1 we_start = we_low_cnt;
        while (ready_s !== 1'b1 && low < 64) begin
            if (low == 1 || low == n + 1) begin
                n_cmp++;
                if (sa_s !== 18'(exp_sa(a, low == n + 1))) begin
                    n_bad++; $display("FAIL sram_addr cyc%0d: got %h want %h", low, sa_s, 18'(exp_sa(a, low == n + 1)));
                end
                n_cmp++;
                if (oe_s !== wr || we_s !== !(wr && n > 1)) begin
                    n_bad++; $display("FAIL bus_ctl cyc%0d: got oe=%b we_n=%b want oe=%b we_n=%b", low, oe_s, we_s, wr, !(wr && n > 1));
                end
                if (wr) begin
                    n_cmp++;
                    if (dqo_s !== ((low == 1) ? d[15:0] : d[31:16])) begin
                        n_bad++; $display("FAIL dq_o cyc%0d: got %h want %h", low, dqo_s, (low == 1) ? d[15:0] : d[31:16]);
                    end
                end
            end
            low++;
            @(negedge clk);
            #1;
        end
        n_cmp++;
        if (low !== 2 * n + 1) begin n_bad++; $display("FAIL ready_low_cycles: got %0d want %0d", low, 2 * n + 1); end
        n_cmp++;
        if (we_low_cnt - we_start !== (wr ? 2 * (n - 1) : 0)) begin
            n_bad++; $display("FAIL we_n_low_count: got %0d want %0d", we_low_cnt - we_start, wr ? 2 * (n - 1) : 0);
        end
        if (!wr) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++; $display("FAIL scoreboard: got empty queue want entry");
            end else begin
                want = exp_q.pop_front();
                if (rdata_s !== want) begin n_bad++; $display("FAIL rdata_done: got %h want %h", rdata_s, want); end
            end
        end
        issue(nxt_wr, nxt_rd, nxt_addr, nxt_wdata);
        nxt_wr = 1'b0; nxt_rd = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        #1;
        n_cmp++;
        if (ready0 !== 1'b1 || ready1 !== 1'b1) begin n_bad++; $display("FAIL reset_ready: got %b%b want 11", ready0, ready1); end
        n_cmp++;
        if (rdata0 !== 32'h0 || rdata1 !== 32'h0) begin n_bad++; $display("FAIL reset_rdata: got %h %h want 0", rdata0, rdata1); end
        n_cmp++;
        if (sa0 !== 18'h0 || dqo0 !== 16'h0) begin n_bad++; $display("FAIL reset_bus: got addr=%h dq=%h want 0", sa0, dqo0); end
        n_cmp++;
        if (oe0 !== 1'b0 || we0 !== 1'b1) begin n_bad++; $display("FAIL reset_ctl: got oe=%b we_n=%b want 0 1", oe0, we0); end
    endtask

    task automatic test_store();
        sel = 1'b0;
        issue(1, 0, 32'd1024, 32'hDEADBEEF);
        xfer(1, 32'd1024, 32'hDEADBEEF);
        n_cmp++;
        if (mem0[0] !== 16'hBEEF || mem0[1] !== 16'hDEAD) begin
            n_bad++; $display("FAIL store_mem: got %h %h want BEEF DEAD", mem0[0], mem0[1]);
        end
    endtask

    task automatic test_load();
        issue(0, 1, 32'd1024, 32'h0);
        xfer(0, 32'd1024, 32'h0);
        for (int i = 0; i < 3; i++) begin
            #1;
            n_cmp++;
            if (rdata0 !== 32'hDEADBEEF || ready0 !== 1'b1) begin
                n_bad++; $display("FAIL idle_hold%0d: got %h rdy=%b want DEADBEEF 1", i, rdata0, ready0);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_addr_map();
        issue(1, 0, 32'd1028, 32'h12345678);
        xfer(1, 32'd1028, 32'h12345678);
        n_cmp++;
        if (mem0[2] !== 16'h5678 || mem0[3] !== 16'h1234) begin
            n_bad++; $display("FAIL map_1028: got %h %h want 5678 1234", mem0[2], mem0[3]);
        end
        issue(1, 0, 32'd1028, 32'hFFFFFFFF);
        xfer(1, 32'd1028, 32'hFFFFFFFF);
        issue(1, 0, 32'd1031, 32'h12345678);
        xfer(1, 32'd1031, 32'h12345678);
        n_cmp++;
        if (mem0[2] !== 16'h5678 || mem0[3] !== 16'h1234) begin
            n_bad++; $display("FAIL map_1031: got %h %h want 5678 1234", mem0[2], mem0[3]);
        end
        issue(1, 0, 32'd1020, 32'hCAFEF00D);
        xfer(1, 32'd1020, 32'hCAFEF00D);
        n_cmp++;
        if (mem0[18'h3FFFE] !== 16'hF00D || mem0[18'h3FFFF] !== 16'hCAFE) begin
            n_bad++; $display("FAIL map_wrap: got %h %h want F00D CAFE", mem0[18'h3FFFE], mem0[18'h3FFFF]);
        end
        n_cmp++;
        if (rdata0 !== 32'hDEADBEEF) begin n_bad++; $display("FAIL rdata_after_writes: got %h want DEADBEEF", rdata0); end
        issue(0, 1, 32'd1020, 32'h0);
        xfer(0, 32'd1020, 32'h0);
    endtask

    task automatic test_back_to_back();
        nxt_wr = 1'b0; nxt_rd = 1'b1; nxt_addr = 32'd1044; nxt_wdata = 32'h0;
        issue(1, 0, 32'd1044, 32'h0BADF00D);
        xfer(1, 32'd1044, 32'h0BADF00D);
        xfer(0, 32'd1044, 32'h0);
        n_cmp++;
        if (mem0[10] !== 16'hF00D || mem0[11] !== 16'h0BAD) begin
            n_bad++; $display("FAIL b2b_mem: got %h %h want F00D 0BAD", mem0[10], mem0[11]);
        end
    endtask

    task automatic test_single_cycle();
        // A one-cycle phase has no we_n low pulse, so the store leaves the array untouched.
        sel = 1'b1;
        issue(1, 0, 32'd1024, 32'hA5A55A5A);
        xfer(1, 32'd1024, 32'hA5A55A5A);
        issue(0, 1, 32'd1024, 32'h0);
        xfer(0, 32'd1024, 32'h0);
        issue(0, 1, 32'd1100, 32'h0);
        xfer(0, 32'd1100, 32'h0);
        sel = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [15:0] old_hi;
        old_hi = mem0[9];
        req_wr = 1'b1; req_rd = 1'b0; req_addr = 32'd1040; req_wdata = 32'h77776666;
        repeat (7) @(negedge clk);
        #1;
        n_cmp++;
        if (we0 !== 1'b0 || oe0 !== 1'b1) begin n_bad++; $display("FAIL pre_reset_ctl: got oe=%b we_n=%b want 1 0", oe0, we0); end
        #2 rst = 1'b1;
        req_wr = 1'b0;
        #1;
        n_cmp++;
        if (we0 !== 1'b1 || oe0 !== 1'b0) begin n_bad++; $display("FAIL async_reset_ctl: got oe=%b we_n=%b want 0 1", oe0, we0); end
        n_cmp++;
        if (rdata0 !== 32'h0 || ready0 !== 1'b1) begin n_bad++; $display("FAIL async_reset_state: got %h rdy=%b want 0 1", rdata0, ready0); end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (mem0[8] !== 16'h6666 || mem0[9] !== old_hi) begin
            n_bad++; $display("FAIL partial_write: got %h %h want 6666 %h", mem0[8], mem0[9], old_hi);
        end
        issue(0, 1, 32'd1024, 32'h0);
        xfer(0, 32'd1024, 32'h0);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        test_reset();
        rst = 1'b0;
        @(negedge clk);
        test_store();
        test_load();
        test_addr_map();
        test_back_to_back();
        test_single_cycle();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
